// File: rtl/uart_tx_stream.sv
// UART transmit engine with an input FIFO: start bit, DATA_BITS data bits LSB first,
// optional parity bit and STOP_BITS stop bits, each bit CLKS_PER_BIT clocks long.
module uart_tx_stream #(
  parameter int unsigned CLKS_PER_BIT = 176,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              in_valid,
  input  logic [DATA_BITS-1:0]              in_data,
  output logic                              in_ready,
  output logic                              uart_txd,
  output logic                              busy,
  output logic                              tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]        level_q, level_d;
  logic                 fifo_full, fifo_empty, push, pop;
  logic [DATA_BITS-1:0] head;

  // Transmit FSM state
  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 txd_q, txd_d;
  logic                 done_q, done_d;
  logic                 bit_end;

  assign fifo_full  = (level_q == LW'(FIFO_DEPTH));
  assign fifo_empty = (level_q == '0);
  assign in_ready   = !fifo_full;
  assign push       = in_valid && !fifo_full;
  assign head       = mem[rd_ptr_q];
  assign level_d    = level_q + LW'(push) - LW'(pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  assign bit_end = (cnt_q == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    txd_d   = txd_q;
    done_d  = 1'b0;
    pop     = 1'b0;

    if (state_q != StIdle) cnt_d = bit_end ? '0 : cnt_q + 1'b1;

    unique case (state_q)
      StIdle: pop = !fifo_empty;
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = BW'(1);
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_q == BW'(DATA_BITS)) begin
            if (PARITY != 0) begin
              state_d = StParity;
              txd_d   = par_q;
            end else begin
              state_d = StStop;
              txd_d   = 1'b1;
              bit_d   = BW'(1);
            end
          end else begin
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          txd_d   = 1'b1;
          bit_d   = BW'(1);
        end
      end
      StStop: begin
        if (bit_end) begin
          if (bit_q == BW'(STOP_BITS)) begin
            done_d = 1'b1;
            if (fifo_empty) state_d = StIdle;
            else            pop     = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A pop always begins a new frame with the start bit
    if (pop) begin
      state_d = StStart;
      txd_d   = 1'b0;
      cnt_d   = '0;
      shift_d = head;
      par_d   = (PARITY == 2) ? ^head : ~^head;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
    end
  end

  assign uart_txd   = txd_q;
  assign tx_done    = done_q;
  assign fifo_level = level_q;
  assign busy       = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_stream.sv
// Directed bench for uart_tx_stream: four instances cover defaults, even/odd parity
// and two stop bits with a short bit period.
module tb_uart_tx_stream;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic       iv0 = 0, iv1 = 0, iv2 = 0, iv3 = 0;
  logic [7:0] id0 = 0, id1 = 0, id2 = 0, id3 = 0;
  logic       rdy0, rdy1, rdy2, rdy3;
  logic       txd0, txd1, txd2, txd3;
  logic       busy0, busy1, busy2, busy3;
  logic       done0, done1, done2, done3;
  logic [3:0] lvl0, lvl1, lvl2, lvl3;

  uart_tx_stream u_def (
    .clk(clk), .resetn(resetn), .in_valid(iv0), .in_data(id0), .in_ready(rdy0),
    .uart_txd(txd0), .busy(busy0), .tx_done(done0), .fifo_level(lvl0)
  );
  uart_tx_stream #(.CLKS_PER_BIT(16), .PARITY(2)) u_even (
    .clk(clk), .resetn(resetn), .in_valid(iv1), .in_data(id1), .in_ready(rdy1),
    .uart_txd(txd1), .busy(busy1), .tx_done(done1), .fifo_level(lvl1)
  );
  uart_tx_stream #(.CLKS_PER_BIT(16), .PARITY(1)) u_odd (
    .clk(clk), .resetn(resetn), .in_valid(iv2), .in_data(id2), .in_ready(rdy2),
    .uart_txd(txd2), .busy(busy2), .tx_done(done2), .fifo_level(lvl2)
  );
  uart_tx_stream #(.CLKS_PER_BIT(4), .STOP_BITS(2)) u_stop2 (
    .clk(clk), .resetn(resetn), .in_valid(iv3), .in_data(id3), .in_ready(rdy3),
    .uart_txd(txd3), .busy(busy3), .tx_done(done3), .fifo_level(lvl3)
  );

  int   sel = 0;
  logic txd_m, done_m;
  always_comb begin
    txd_m  = txd0;
    done_m = done0;
    case (sel)
      1: begin txd_m = txd1; done_m = done1; end
      2: begin txd_m = txd2; done_m = done2; end
      3: begin txd_m = txd3; done_m = done3; end
      default: ;
    endcase
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] burst_byte(input int k);
    return 8'(k * 29 + 15);
  endfunction

  // Waits (bounded) for a start bit on the selected line, then samples mid-bit values and
  // records the clock count from start-bit fall to tx_done. Returns at the negedge that
  // follows the final edge, which is the start of any back-to-back frame.
  task automatic rx_frame(input int cpb, input int nbits, output logic [15:0] bits,
                          output int len, output int wait_cyc);
    bits = '0;
    len = -1;
    wait_cyc = 0;
    while (txd_m !== 1'b0 && wait_cyc < 20000) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (txd_m !== 1'b0) begin
      check("rx_start_seen", {31'b0, txd_m}, 32'd0);
      return;
    end
    for (int t = 0; t <= nbits * cpb; t++) begin
      if (t > 0) @(negedge clk);
      if ((t % cpb) == cpb / 2 && t / cpb < nbits) bits[t/cpb] = txd_m;
      if (t > 0 && done_m === 1'b1 && len < 0) len = t;
    end
  endtask

  logic [15:0] bits;
  int          len, wcyc, acc, g, lows;

  initial begin
    // Reset with in_valid held high: nothing may be pushed
    iv0 = 1; iv1 = 1; iv2 = 1; iv3 = 1;
    repeat (4) @(negedge clk);
    check("rst_txd", {31'b0, txd0}, 32'd1);
    check("rst_ready", {31'b0, rdy0}, 32'd1);
    check("rst_busy", {31'b0, busy0}, 32'd0);
    check("rst_level", {28'b0, lvl0}, 32'd0);
    check("rst_done", {31'b0, done0}, 32'd0);
    check("rst_stop2_line", {28'b0, txd3, busy3, rdy3, done3}, 32'b1010);
    iv0 = 0; iv1 = 0; iv2 = 0; iv3 = 0;
    @(negedge clk);
    resetn = 1;
    repeat (3) @(negedge clk);
    check("post_rst_level", {28'b0, lvl0}, 32'd0);

    // Defaults, single byte 8'h30
    sel = 0;
    iv0 = 1; id0 = 8'h30;
    @(negedge clk);
    iv0 = 0;
    check("push_level", {28'b0, lvl0}, 32'd1);
    check("push_line_idle", {31'b0, txd0}, 32'd1);
    rx_frame(176, 10, bits, len, wcyc);
    check("start_latency", wcyc, 32'd1);
    check("frame_30_bits", {16'b0, bits}, 32'h260);
    check("frame_30_len", len, 32'd1760);
    check("busy_after_frame", {31'b0, busy0}, 32'd0);
    @(negedge clk);
    check("done_one_cycle", {31'b0, done0}, 32'd0);
    check("line_idle_after", {31'b0, txd0}, 32'd1);

    // Parity: even then odd on 8'h07
    sel = 1;
    iv1 = 1; id1 = 8'h07;
    @(negedge clk);
    iv1 = 0;
    rx_frame(16, 11, bits, len, wcyc);
    check("even_bits", {16'b0, bits}, 32'h60E);
    check("even_len", len, 32'd176);
    sel = 2;
    iv2 = 1; id2 = 8'h07;
    @(negedge clk);
    iv2 = 0;
    rx_frame(16, 11, bits, len, wcyc);
    check("odd_bits", {16'b0, bits}, 32'h40E);
    check("odd_len", len, 32'd176);

    // Ten-byte burst into the default instance
    sel = 0;
    fork
      begin
        iv0 = 1;
        acc = 0;
        while (rdy0 && acc < 10) begin
          id0 = burst_byte(acc);
          @(negedge clk);
          acc++;
        end
        check("burst_accepted", acc, 32'd9);
        check("burst_level_full", {28'b0, lvl0}, 32'd8);
        check("burst_ready_low", {31'b0, rdy0}, 32'd0);
        id0 = burst_byte(acc);
        g = 0;
        while (!rdy0 && g < 5000) begin
          @(negedge clk);
          g++;
        end
        check("ready_at_frame0_end", {30'b0, rdy0, done0}, 32'b11);
        @(negedge clk);
        iv0 = 0;
      end
      begin
        for (int k = 0; k < 10; k++) begin
          rx_frame(176, 10, bits, len, wcyc);
          check($sformatf("burst_bits_%0d", k), {16'b0, bits},
                {22'b0, 1'b1, burst_byte(k), 1'b0});
          check($sformatf("burst_len_%0d", k), len, 32'd1760);
          if (k > 0) check($sformatf("burst_gap_%0d", k), wcyc, 32'd0);
        end
      end
    join
    check("burst_drained", {31'b0, busy0}, 32'd0);

    // Two stop bits, four clocks per bit
    sel = 3;
    iv3 = 1; id3 = 8'h55;
    @(negedge clk);
    id3 = 8'hAA;
    @(negedge clk);
    iv3 = 0;
    rx_frame(4, 11, bits, len, wcyc);
    check("stop2_f0_bits", {16'b0, bits}, {21'b0, 2'b11, 8'h55, 1'b0});
    check("stop2_f0_len", len, 32'd44);
    rx_frame(4, 11, bits, len, wcyc);
    check("stop2_f1_gap", wcyc, 32'd0);
    check("stop2_f1_bits", {16'b0, bits}, {21'b0, 2'b11, 8'hAA, 1'b0});
    check("stop2_f1_len", len, 32'd44);

    // Reset mid-data of a queued burst of zero bytes
    sel = 0;
    iv0 = 1; id0 = 8'h00;
    repeat (3) @(negedge clk);
    iv0 = 0;
    g = 0;
    while (txd0 !== 1'b0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    repeat (176 * 3 + 88) @(negedge clk);
    check("mid_data_line", {31'b0, txd0}, 32'd0);
    check("mid_data_level", {28'b0, lvl0}, 32'd2);
    resetn = 0;
    #1;
    check("async_rst_txd", {31'b0, txd0}, 32'd1);
    check("async_rst_level", {28'b0, lvl0}, 32'd0);
    check("async_rst_busy", {31'b0, busy0}, 32'd0);
    @(negedge clk);
    resetn = 1;
    lows = 0;
    repeat (2000) begin
      @(negedge clk);
      if (txd0 !== 1'b1 || busy0 !== 1'b0) lows++;
    end
    check("no_residual_bits", lows, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
